// File: rtl/cla_seq_pkg.sv
// Shared constants, state encoding and sizing helper for the sequential CLA adder.
package cla_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // Slice index width; never narrower than one bit.
    function automatic int unsigned IDX_W(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cla_seq_adder_cla.sv
// Four-bit carry-lookahead adder slice.
module CLA_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout,
    output logic [3:0] sum
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Carries expanded from generate/propagate terms rather than rippled.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one CLA_4_bit slice is reused for every nibble, carry held in a register.
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int unsigned N_SLICES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE_W*N_SLICES-1:0] a,
    input  logic [SLICE_W*N_SLICES-1:0] b,
    input  logic                        cin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SLICE_W*N_SLICES-1:0] sum,
    output logic                        cout,
    output logic                        ovf,
    output logic                        busy
);

    localparam int unsigned IW = IDX_W(N_SLICES);

    state_t state;
    state_t state_nxt;
    logic   load;
    logic   step;
    logic   last;

    logic [IW-1:0]                     idx;
    logic [N_SLICES-1:0][SLICE_W-1:0]  a_q;
    logic [N_SLICES-1:0][SLICE_W-1:0]  b_q;
    logic [N_SLICES-1:0][SLICE_W-1:0]  sum_q;
    logic                              carry_q;

    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;

    assign last = (idx == IW'(N_SLICES - 1));
    assign sum  = sum_q;

    CLA_4_bit u_cla (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry_q),
        .cout (slice_cout),
        .sum  (slice_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the load/step strobes for the datapath.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake flags registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt == RUN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (load) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx     <= '0;
            end
            if (step) begin
                sum_q[idx] <= slice_sum;
                carry_q    <= slice_cout;
                if (last) begin
                    cout <= slice_cout;
                    ovf  <= (a_q[N_SLICES-1][SLICE_W-1] == b_q[N_SLICES-1][SLICE_W-1])
                         && (slice_sum[SLICE_W-1] != a_q[N_SLICES-1][SLICE_W-1]);
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_seq_adder.sv
// Randomized self-checking bench for cla_seq_adder (N_SLICES=4) against an arithmetic model.
module tb_cla_seq_adder;

    localparam int unsigned NS = 4;
    localparam int unsigned W  = 4 * NS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_vec  = 0;
    int n_miss = 0;

    cla_seq_adder #(.N_SLICES(NS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one pair, wait for the result, stall, compare with plain arithmetic, then retire it.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input int stall);
        logic [W:0]   full;
        logic         exp_ovf;
        logic [W-1:0] held;
        int           cnt;
        full    = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
        exp_ovf = (ta[W-1] == tb_[W-1]) && (full[W-1] != ta[W-1]);

        check("in_ready_before", 32'(in_ready), 32'd1);
        a = ta; b = tb_; cin = tc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("busy_in_run", 32'(busy), 32'd1);
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check("latency", 32'(cnt), 32'(NS));

        held = sum;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            tick();
            check("stall_sum", 32'(sum), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;

        check("sum", 32'(sum), 32'(full[W-1:0]));
        check("cout", 32'(cout), 32'(full[W]));
        check("ovf", 32'(ovf), 32'(exp_ovf));

        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("retire_out_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op(16'h000B, 16'h0001, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 5);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 0);

        // Abandon an operation two cycles into RUN.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(16'h1234, 16'h4321, 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
